// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, load results are
// buffered in a small FIFO, and a pending-destination mask guards RAW hazards.
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_data,
    output logic             RegWrite,
    output logic [4:0]       WriteReg,
    output logic [31:0]      WriteData,
    output logic [31:0]      pending,
    output logic [PTR_W:0]   fifo_count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    // Output register state
    logic             wr_en_q,   wr_en_d;
    logic [4:0]       wr_reg_q,  wr_reg_d;
    logic [31:0]      wr_data_q, wr_data_d;

    // Load FIFO state
    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [4:0]       fifo_rd_d   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [31:0]      pending_q, pending_d;

    // Arbitration results
    logic             mem_accept;
    logic             win;
    logic [4:0]       win_rd;
    logic [31:0]      win_data;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] slot;

    // Ready depends on registered occupancy only, so it never loops through alu_valid.
    assign mem_ready  = rst && (count_q < DEPTH_C);
    assign mem_accept = mem_valid && mem_ready;

    always_comb begin
        win      = 1'b0;
        win_rd   = 5'd0;
        win_data = 32'd0;
        push     = 1'b0;
        pop      = 1'b0;
        if (alu_valid) begin
            win      = 1'b1;
            win_rd   = alu_rd;
            win_data = alu_data;
            push     = mem_accept;
        end else if (count_q != '0) begin
            win      = 1'b1;
            win_rd   = fifo_rd_q[rd_ptr_q];
            win_data = fifo_data_q[rd_ptr_q];
            pop      = 1'b1;
            push     = mem_accept;
        end else if (mem_accept) begin
            win      = 1'b1;
            win_rd   = mem_rd;
            win_data = mem_data;
        end
    end

    always_comb begin
        wr_en_d   = win && (win_rd != 5'd0);
        wr_reg_d  = win ? win_rd   : wr_reg_q;
        wr_data_d = win ? win_data : wr_data_q;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        fifo_rd_d = fifo_rd_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q] = mem_rd;
        end

        // Mask is rebuilt from the post-edge occupied slots so it never goes stale.
        pending_d = 32'd0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PTR_W'(i) - rd_ptr_d;
            if (({1'b0, slot} < count_d) && (fifo_rd_d[i] != 5'd0)) begin
                pending_d[fifo_rd_d[i]] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 32'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Slot payloads need no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_rd_q <= fifo_rd_d;
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    assign RegWrite   = wr_en_q;
    assign WriteReg   = wr_reg_q;
    assign WriteData  = wr_data_q;
    assign pending    = pending_q;
    assign fifo_count = count_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Write-side front end of the integer register file. Merges writeback results from two producers into the register file's single write port (RegWrite/WriteReg/WriteData): the single-cycle ALU path and the variable-latency memory/load path. Load results that lose arbitration are buffered in a small FIFO. A pending-destination mask is exported so decode can stall on RAW hazards against buffered loads.

Parameters:
DEPTH, 2, load-result FIFO entries (power of two, >=2)
PTR_W, 1, log2(DEPTH); pointer width

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result valid this cycle; always accepted, no ready
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted this cycle when mem_valid&&mem_ready
mem_rd  in  5  load destination register
mem_data  in  32  load result
RegWrite  out  1  register file write enable (registered)
WriteReg  out  5  register file write address (registered)
WriteData  out  32  register file write data (registered)
pending  out  32  bit r=1 iff some FIFO entry targets xr (bit 0 always 0)
fifo_count  out  PTR_W+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): RegWrite=0, WriteReg=0, WriteData=0, FIFO empty (pointers and count 0), pending=0. mem_ready=0 while rst=0. Reset mid-operation discards buffered loads.
- mem_ready = rst && (fifo_count < DEPTH); combinational from state only, never from alu_valid.
- Per-cycle arbitration, evaluated in priority order; the winner drives the output registers at the next edge, so latency is 1 cycle.
  1. alu_valid: the ALU wins. An accepted load is pushed into the FIFO. The FIFO head is not popped.
  2. else FIFO non-empty: pop the head to the output. An accepted load is pushed in the same cycle. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  3. else accepted load with FIFO empty: direct path to the output. No push, count stays 0.
  4. else: RegWrite=0 next cycle. WriteReg and WriteData hold their last values.
- Destination x0: a winner with rd=0 produces RegWrite=0 that cycle but is still consumed (popped or accepted). Loads with rd=0 are still buffered in order, but do not set pending[0].
- The FIFO preserves load order. The ALU may overtake buffered loads; ordering between ports is upstream's job via pending.
- pending is recomputed from valid FIFO entries each cycle, registered alongside the FIFO. It reflects the post-edge contents.
- Full FIFO: mem_ready=0, and the producer holds mem_valid/mem_rd/mem_data stable until accepted. A push never occurs when count==DEPTH, even if a pop happens in the same cycle.
- RegWrite is a one-cycle pulse per winning non-x0 result. Back-to-back wins give consecutive pulses with no gap.

Test Plan:
- Reset: push 2 loads, then drop rst to 0 mid-stream -> immediately RegWrite=0, WriteReg=0, WriteData=0, fifo_count=0, pending=0, mem_ready=0. After release, mem_ready=1.
- ALU only: alu_valid=1, rd=1, data=32 for one cycle -> next edge RegWrite=1, WriteReg=1, WriteData=32. The following cycle RegWrite=0.
- Conflict: same cycle ALU rd=31 data=21 and load rd=5 data=200 -> edge1 writes x31=21, pending[5]=1, count=1. Edge2 writes x5=200, pending=0, count=0.
- Back-pressure: alu_valid for 4 cycles while loads rd=2,3,4 (data 2,3,4) are offered continuously -> 2 accepted, mem_ready=0, rd=4 held. Once the ALU idles: writes x2, x3, x4 in order on consecutive cycles, with rd=4 accepted as the first pop frees space.
- x0 drop: ALU rd=0 data=128 -> RegWrite stays 0. Load rd=0 buffered behind the ALU -> consumed with no write, pending stays 0.
- Direct path: FIFO empty, load only rd=7 data=2 -> next edge writes x7=2, fifo_count stays 0 throughout.
